branch_ctrl: RTL

ID-stage branch controller that sequences the shared 32-bit branch comparator (equal / non-negative outputs). It accepts one decoded branch at a time and configures the comparator inputs per branch type. It stalls fetch/decode until operands are hazard-free, resolves the branch condition and issues a one-cycle redirect to the PC unit. It also keeps saturating branch statistics for the debug register file.

---
 rtl/branch_pkg.sv | 31 +++
 rtl/branch_ctrl_if.sv | 15 +
 rtl/branch_cond.sv | 27 ++
 rtl/branch_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the ID-stage branch controller: branch opcodes,
// controller states, the zero compare operand and an operand-usage helper.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BGEZ = 3'd2,
    BR_BLTZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLEZ = 3'd5,
    BR_RSV6 = 3'd6,
    BR_RSV7 = 3'd7
  } br_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Second comparator operand for the zero-compare branches.
  localparam logic [63:0] ZERO_OPND = 64'd0;

  // Only the two-register compares read rt; all others compare rs to zero.
  function automatic logic uses_rt(input br_op_t op);
    return (op == BR_BEQ) || (op == BR_BNE);
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decoded-branch handshake from the decoder into the branch controller.
// valid/ready: a branch transfers on a clock edge where br_valid and
// br_ready are both high; br_op/br_target must be stable while br_valid is
// high and are not looked at again once the transfer has happened.
interface branch_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_op;
  logic [WIDTH-1:0] br_target;

  modport master (output br_valid, output br_op, output br_target, input br_ready);
  modport slave  (input br_valid, input br_op, input br_target, output br_ready);
endinterface

// File: rtl/branch_cond.sv
// Branch condition decode: turns the comparator flags into taken/illegal.
module branch_cond
  import branch_pkg::*;
(
  input  br_op_t op,
  input  logic   eq,
  input  logic   gtz,
  output logic   taken,
  output logic   illegal
);

  // Condition table; reserved encodings never branch and flag illegal.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (op)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_BGEZ: taken = gtz;
      BR_BLTZ: taken = !gtz;
      BR_BGTZ: taken = gtz & !eq;
      BR_BLEZ: taken = !gtz | eq;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: waits for hazard-free operands, drives the
// shared comparator, resolves the branch, pulses a redirect and keeps
// saturating branch statistics.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DELAY_SLOT = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_ctrl_if.slave     br,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             rs_busy,
  input  logic             rt_busy,
  output logic [WIDTH-1:0] cmp_d1,
  output logic [WIDTH-1:0] cmp_d2,
  input  logic             cmp_equal,
  input  logic             cmp_gtzero,
  output logic             stall_o,
  output logic             done_o,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush_o,
  output logic             illegal_o,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_taken,
  output state_t           state_dbg
);

  state_t           state;
  br_op_t           op_q;
  logic [WIDTH-1:0] target_q;
  logic             taken_q;
  logic             illegal_q;

  br_op_t           op_sel;
  logic             need_rt;
  logic             opnd_busy;
  logic [WIDTH-1:0] d2_next;
  logic             cond_taken;
  logic             cond_illegal;

  // In IDLE the op comes straight from the decoder; afterwards from the latch.
  assign op_sel    = (state == ST_IDLE) ? br_op_t'(br.br_op) : op_q;
  assign need_rt   = uses_rt(op_sel);
  assign opnd_busy = rs_busy | (need_rt & rt_busy);
  assign d2_next   = need_rt ? rt_data : ZERO_OPND[WIDTH-1:0];

  branch_cond u_cond (
    .op      (op_q),
    .eq      (cmp_equal),
    .gtz     (cmp_gtzero),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign br.br_ready     = (state == ST_IDLE);
  assign stall_o         = ((state == ST_IDLE) & br.br_valid) | (state == ST_WAIT) | (state == ST_EVAL);
  assign done_o          = (state == ST_DONE);
  assign redirect_valid  = (state == ST_DONE) & taken_q;
  assign illegal_o       = (state == ST_DONE) & illegal_q;
  assign flush_o         = redirect_valid & (DELAY_SLOT == 0);
  assign state_dbg       = state;

  // Branch sequencing: accept, wait for operands, capture, evaluate, report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= BR_BEQ;
      target_q    <= '0;
      cmp_d1      <= '0;
      cmp_d2      <= '0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      redirect_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (br.br_valid) begin
            op_q     <= br_op_t'(br.br_op);
            target_q <= br.br_target;
            if (opnd_busy) begin
              state <= ST_WAIT;
            end else begin
              cmp_d1 <= rs_data;
              cmp_d2 <= d2_next;
              state  <= ST_EVAL;
            end
          end
        end
        ST_WAIT: begin
          if (!opnd_busy) begin
            cmp_d1 <= rs_data;
            cmp_d2 <= d2_next;
            state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          taken_q     <= cond_taken;
          illegal_q   <= cond_illegal;
          redirect_pc <= target_q;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (stat_clr) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else if (state == ST_DONE) begin
      if (stat_branches != {CNT_W{1'b1}}) stat_branches <= stat_branches + CNT_W'(1);
      if (taken_q && (stat_taken != {CNT_W{1'b1}})) stat_taken <= stat_taken + CNT_W'(1);
    end
  end

endmodule
